// File: rtl/servo_pwm_bank.sv
// Multi-channel servo/ESC pulse generator: tick prescaler, shared period counter, shadow/active widths
// committed at the period boundary with optional slew limit, and a write-watchdog forcing a safe width.
module servo_pwm_bank #(
  parameter int CHANNELS        = 4,
  parameter int WIDTH           = 8,
  parameter int CLK_DIV         = 47,
  parameter int MIN_TICKS       = 255,
  parameter int PERIOD_TICKS    = 5100,
  parameter int DEFAULT_WIDTH   = 127,
  parameter int SLEW_STEP       = 0,
  parameter int TIMEOUT_PERIODS = 50,
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_12MHz,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CHW-1:0]      wr_chan,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_start,
  output logic                failsafe
);

  localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW  = $clog2(PERIOD_TICKS) + 1;
  localparam int WDW = (TIMEOUT_PERIODS > 0) ? $clog2(TIMEOUT_PERIODS + 1) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0]    COUNT_LAST = CW'(PERIOD_TICKS - 1);
  localparam logic [CW-1:0]    MIN_T      = CW'(MIN_TICKS);
  localparam logic [WIDTH-1:0] DEF_W      = WIDTH'(DEFAULT_WIDTH);
  localparam logic [WIDTH:0]   STEP_W     = (SLEW_STEP >= 2**WIDTH) ? (WIDTH+1)'(2**WIDTH)
                                                                    : (WIDTH+1)'(SLEW_STEP);
  localparam logic [WDW-1:0]   WD_MAX     = WDW'(TIMEOUT_PERIODS);
  localparam logic [WDW-1:0]   WD_LAST    = WDW'((TIMEOUT_PERIODS > 0) ? TIMEOUT_PERIODS - 1 : 0);

  logic [PW-1:0]    presc;
  logic [CW-1:0]    count;
  logic [WDW-1:0]   wd_cnt;
  logic [CHANNELS-1:0] en_lat;
  logic [WIDTH-1:0] target [CHANNELS];
  logic [WIDTH-1:0] active [CHANNELS];

  logic tick;
  logic boundary;
  logic fs_next;

  // One step of the active code toward the target; one extra bit keeps the difference from wrapping.
  function automatic logic [WIDTH-1:0] slew_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0]   c;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] res;
    c   = {1'b0, cur};
    t   = {1'b0, tgt};
    res = tgt;
    if (STEP_W != '0) begin
      if (t > c) begin
        if ((t - c) > STEP_W) res = WIDTH'(c + STEP_W);
      end else begin
        if ((c - t) > STEP_W) res = WIDTH'(c - STEP_W);
      end
    end
    return res;
  endfunction

  always_comb begin
    tick     = (presc == PRESC_LAST);
    boundary = tick && (count == COUNT_LAST);
    fs_next  = failsafe;
    if (wr_en)
      fs_next = 1'b0;
    else if ((TIMEOUT_PERIODS > 0) && boundary && (wd_cnt == WD_LAST))
      fs_next = 1'b1;
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      presc        <= '0;
      count        <= '0;
      wd_cnt       <= '0;
      failsafe     <= 1'b0;
      period_start <= 1'b0;
      pwm          <= '0;
      en_lat       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= DEF_W;
        active[i] <= DEF_W;
      end
      assert (PERIOD_TICKS > MIN_TICKS + 2**WIDTH - 1)
        else $error("servo_pwm_bank: PERIOD_TICKS too small for MIN_TICKS and WIDTH");
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        count <= (count == COUNT_LAST) ? '0 : count + 1'b1;
      period_start <= boundary;
      failsafe     <= fs_next;

      // A write in the expiry cycle wins: the count restarts and failsafe stays low.
      if (wr_en)
        wd_cnt <= '0;
      else if ((TIMEOUT_PERIODS > 0) && boundary && (wd_cnt != WD_MAX))
        wd_cnt <= wd_cnt + 1'b1;

      if (boundary)
        en_lat <= enable;

      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_chan == CHW'(i)))
          target[i] <= wr_data;
        if (boundary)
          active[i] <= fs_next ? DEF_W : slew_step(active[i], target[i]);
        pwm[i] <= en_lat[i] && (count < (MIN_T + CW'(active[i])));
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: three instances (plain, slew-limited, watchdog) share one stimulus bus;
// pulse widths are measured in clk cycles per period and compared against hand-computed tick counts.
module tb_servo_pwm_bank;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_chan;
  logic [7:0] wr_data;
  logic [1:0] enable;

  logic [1:0] pwm_a;
  logic       ps_a, fs_a;
  logic [1:0] pwm_b;
  logic       ps_b, fs_b;
  logic [4:0] pwm_c;
  logic       ps_c, fs_c;

  int checks   = 0;
  int failures = 0;

  int hi_a0, hi_a1, hi_b0, hi_b1, hi_c0;
  int fs_first, fs_last, extra_ps, wait_n;

  servo_pwm_bank #(.CHANNELS(2), .WIDTH(8), .CLK_DIV(2), .MIN_TICKS(255), .PERIOD_TICKS(600),
                   .DEFAULT_WIDTH(127), .SLEW_STEP(0), .TIMEOUT_PERIODS(0)) dut_a (
    .clk_12MHz(clk), .reset(reset), .wr_en(wr_en), .wr_chan(wr_chan[0]), .wr_data(wr_data),
    .enable(enable), .pwm(pwm_a), .period_start(ps_a), .failsafe(fs_a));

  servo_pwm_bank #(.CHANNELS(2), .WIDTH(8), .CLK_DIV(2), .MIN_TICKS(255), .PERIOD_TICKS(600),
                   .DEFAULT_WIDTH(127), .SLEW_STEP(10), .TIMEOUT_PERIODS(0)) dut_b (
    .clk_12MHz(clk), .reset(reset), .wr_en(wr_en), .wr_chan(wr_chan[0]), .wr_data(wr_data),
    .enable(enable), .pwm(pwm_b), .period_start(ps_b), .failsafe(fs_b));

  servo_pwm_bank #(.CHANNELS(5), .WIDTH(8), .CLK_DIV(2), .MIN_TICKS(255), .PERIOD_TICKS(600),
                   .DEFAULT_WIDTH(127), .SLEW_STEP(0), .TIMEOUT_PERIODS(3)) dut_c (
    .clk_12MHz(clk), .reset(reset), .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data),
    .enable({3'b000, enable}), .pwm(pwm_c), .period_start(ps_c), .failsafe(fs_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not complete, got no summary, required finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    int         wr_at;   // cycle offset of a write within the period, -1 = none
    int         wch;
    int         wdat;
    int         en_at;   // cycle offset of an enable change, -1 = none
    logic [1:0] en;
    int         a0, a1, b0, b1;  // expected high time in ticks during this period
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits for period_start (bounded), then samples one full 1200-cycle period, driving stimulus at given offsets.
  task automatic run_period(input int wr_at, input int wch, input int wdat,
                            input int en_at, input logic [1:0] en_val);
    int n;
    n = 0;
    while (!ps_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    wait_n = n;
    if (!ps_a) chk("period_start_wait", 0, 1);
    hi_a0 = 0; hi_a1 = 0; hi_b0 = 0; hi_b1 = 0; hi_c0 = 0;
    extra_ps = 0; fs_first = 0; fs_last = 0;
    for (int i = 0; i < 1200; i++) begin
      hi_a0 += int'(pwm_a[0]);
      hi_a1 += int'(pwm_a[1]);
      hi_b0 += int'(pwm_b[0]);
      hi_b1 += int'(pwm_b[1]);
      hi_c0 += int'(pwm_c[0]);
      if (i == 0)    fs_first = int'(fs_c);
      if (i == 1199) fs_last  = int'(fs_c);
      if (i > 0 && ps_a) extra_ps++;
      if (i == wr_at) begin
        wr_chan = 3'(wch);
        wr_data = 8'(wdat);
        wr_en   = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      if (i == en_at) enable = en_val;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_now(input int wch, input int wdat);
    wr_chan = 3'(wch);
    wr_data = 8'(wdat);
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Counts cycles from the current one until period_start, accumulating pwm_a high samples.
  task automatic cycles_to_ps(output int n, output int hi);
    n  = 0;
    hi = 0;
    while (!ps_a && n < 3000) begin
      @(negedge clk);
      n++;
      hi += int'(pwm_a[0]) + int'(pwm_a[1]);
    end
  endtask

  initial begin
    int n, hi;

    tbl[0]  = '{-1,   0, 0,   -1, 2'b11, 382, 382, 382, 382};
    tbl[1]  = '{200,  0, 200, -1, 2'b11, 382, 382, 382, 382};
    tbl[2]  = '{-1,   0, 0,   -1, 2'b11, 455, 382, 392, 382};
    tbl[3]  = '{-1,   0, 0,   -1, 2'b11, 455, 382, 402, 382};
    tbl[4]  = '{-1,   0, 0,   -1, 2'b11, 455, 382, 412, 382};
    tbl[5]  = '{-1,   0, 0,   -1, 2'b11, 455, 382, 422, 382};
    tbl[6]  = '{-1,   0, 0,   -1, 2'b11, 455, 382, 432, 382};
    tbl[7]  = '{-1,   0, 0,   -1, 2'b11, 455, 382, 442, 382};
    tbl[8]  = '{-1,   0, 0,   -1, 2'b11, 455, 382, 452, 382};
    tbl[9]  = '{200,  0, 0,   -1, 2'b11, 455, 382, 455, 382};
    tbl[10] = '{1199, 1, 255, -1, 2'b11, 255, 382, 445, 382};
    tbl[11] = '{-1,   0, 0,   -1, 2'b11, 255, 382, 435, 382};
    tbl[12] = '{-1,   0, 0,   -1, 2'b11, 255, 510, 425, 392};
    tbl[13] = '{-1,   0, 0,  200, 2'b10, 255, 510, 415, 402};
    tbl[14] = '{-1,   0, 0,   -1, 2'b10,   0, 510,   0, 412};
    tbl[15] = '{-1,   0, 0,  200, 2'b11,   0, 510,   0, 422};
    tbl[16] = '{-1,   0, 0,   -1, 2'b11, 255, 510, 385, 432};

    reset = 1'b1; wr_en = 1'b0; wr_chan = '0; wr_data = '0; enable = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_pwm_a", int'(pwm_a), 0);
    chk("rst_pwm_b", int'(pwm_b), 0);
    chk("rst_pwm_c", int'(pwm_c), 0);
    chk("rst_ps_a",  int'(ps_a),  0);
    chk("rst_fs_a",  int'(fs_a),  0);
    chk("rst_fs_b",  int'(fs_b),  0);
    chk("rst_fs_c",  int'(fs_c),  0);
    chk("rst_ps_c",  int'(ps_c),  0);
    enable = 2'b11;
    reset  = 1'b0;

    // Defaults, mid-period and boundary-cycle writes, slew up/down, enable drop and restore.
    for (int r = 0; r < 17; r++) begin
      run_period(tbl[r].wr_at, tbl[r].wch, tbl[r].wdat, tbl[r].en_at, tbl[r].en);
      chk($sformatf("row%0d_a0", r), hi_a0, 2 * tbl[r].a0);
      chk($sformatf("row%0d_a1", r), hi_a1, 2 * tbl[r].a1);
      chk($sformatf("row%0d_b0", r), hi_b0, 2 * tbl[r].b0);
      chk($sformatf("row%0d_b1", r), hi_b1, 2 * tbl[r].b1);
      chk($sformatf("row%0d_extra_ps", r), extra_ps, 0);
      if (r > 0) chk($sformatf("row%0d_ps_spacing", r), wait_n, 0);
    end

    // Watchdog: expiry at the third quiet boundary, invalid-channel recovery, write in the expiry cycle.
    do_reset();
    enable = 2'b11;
    write_now(0, 200);
    run_period(-1, 0, 0, -1, 2'b11);
    chk("wd_p1_c0", hi_c0, 910);
    chk("wd_p1_fs", fs_first, 0);
    run_period(-1, 0, 0, -1, 2'b11);
    chk("wd_p2_c0", hi_c0, 910);
    chk("wd_p2_fs", fs_first, 0);
    run_period(200, 7, 0, -1, 2'b11);
    chk("wd_p3_c0_failsafe", hi_c0, 764);
    chk("wd_p3_fs_set", fs_first, 1);
    chk("wd_p3_fs_cleared", fs_last, 0);
    run_period(-1, 0, 0, -1, 2'b11);
    chk("wd_p4_c0_recovered", hi_c0, 910);
    chk("wd_p4_fs", fs_first, 0);
    run_period(1199, 7, 0, -1, 2'b11);
    chk("wd_p5_c0", hi_c0, 910);
    run_period(-1, 0, 0, -1, 2'b11);
    chk("wd_p6_write_beats_expiry", fs_first, 0);
    chk("wd_p6_c0", hi_c0, 910);

    // Reset mid-pulse and in the boundary cycle.
    do_reset();
    enable = 2'b11;
    write_now(0, 0);
    run_period(-1, 0, 0, -1, 2'b11);
    chk("rs_pre_a0", hi_a0, 510);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rs_mid_pwm", int'(pwm_a), 0);
    chk("rs_mid_ps", int'(ps_a), 0);
    chk("rs_mid_fs", int'(fs_c), 0);
    cycles_to_ps(n, hi);
    chk("rs_mid_cycles_to_ps", n, 1200);
    chk("rs_mid_pwm_after", hi, 0);
    run_period(-1, 0, 0, -1, 2'b11);
    chk("rs_mid_a0_default", hi_a0, 764);
    chk("rs_mid_a1_default", hi_a1, 764);
    repeat (1199) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rs_end_ps", int'(ps_a), 0);
    chk("rs_end_pwm", int'(pwm_a), 0);
    cycles_to_ps(n, hi);
    chk("rs_end_cycles_to_ps", n, 1200);
    chk("rs_end_pwm_after", hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
